// File: rtl/io_input_unit.sv
// I/O unit for the ZAFx32 datapath: operator-paced IN capture from switches
// behind a debounced Enter button, and an OUT-driven display register.
module io_input_unit #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int SW_WIDTH        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                btn_enter,
   input  logic                in_req,
   input  logic                out_we,
   input  logic [31:0]         out_data,
   output logic [31:0]         io_data,
   output logic                stall,
   output logic                in_done,
   output logic [31:0]         display,
   output logic                waiting
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic                btn_m, btn_s;
   logic [SW_WIDTH-1:0] sw_m, sw_s;
   logic [CNT_W-1:0]    cnt;
   logic                btn_db, btn_db_d, press;
   logic [31:0]         sw_ext;

   // Two-flop synchronizers for the asynchronous board inputs.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the two stages into one.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
         sw_m  <= '0;
         sw_s  <= '0;
      end else begin
         btn_m <= btn_enter;
         btn_s <= btn_m;
         sw_m  <= sw;
         sw_s  <= sw_m;
      end
   end

   // Debouncer: btn_db only follows btn_s after DEBOUNCE_CYCLES unbroken cycles
   // of disagreement; press fires once, the cycle after btn_db rises.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
         press    <= 1'b0;
      end else begin
         btn_db_d <= btn_db;
         press    <= btn_db & ~btn_db_d;
         if (btn_s == btn_db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            btn_db <= ~btn_db;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (in_req) state_next = S_WAIT;
         S_WAIT: begin
            // A dropped request abandons the capture before a press can land.
            if (!in_req)    state_next = S_IDLE;
            else if (press) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      sw_ext                 = '0;
      sw_ext[SW_WIDTH-1:0]   = sw_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_data <= '0;
      end else if (state == S_WAIT && in_req && press) begin
         io_data <= sw_ext;
      end
   end

   // The display path runs independently of the IN handshake.
   always_ff @(posedge clk) begin
      if (rst)         display <= '0;
      else if (out_we) display <= out_data;
   end

   assign stall   = (state == S_IDLE && in_req) || (state == S_WAIT);
   assign in_done = (state == S_DONE);
   assign waiting = (state == S_WAIT);

endmodule
